// File: rtl/controlunit_tx.sv
// UART transmit control unit: latches a byte and line control, builds the 11-bit frame and shifts it out LSB first.
// Optional one-deep request holding register is enabled with `define CONTROLUNIT_TX_HOLD_EN.
module controlunit_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tx_data,
  input  logic [4:0]  line_control_reg,
  input  logic        tx_start,
  input  logic        baud_tick,
  output logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_serial,
  output logic [10:0] parallel_data_tx,
  output logic        transmission_done_flag
);
  localparam int CW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tick_cnt, tick_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  // parity sense is already folded into the frame, so only [3:0] is kept
  logic [3:0]    lcr;
  logic [10:0]   frame_nxt;
  logic [7:0]    data_bits;
  logic [7:0]    src_data;
  logic [4:0]    src_lcr;
  logic          bit_end, last_stop, frame_done;
  logic          load, load_direct, load_hold, serial_nxt;

  function automatic logic [10:0] build_frame(input logic [7:0] d, input logic [4:0] l);
    logic [7:0] mask;
    logic       par;
    mask = 8'hFF >> (2'd3 - l[1:0]);
    par  = ^(d & mask) ^ ~l[4];
    if (!l[3]) par = 1'b1;
    return {1'b1, par, d | ~mask, 1'b0};
  endfunction

  assign tx_busy     = (state != IDLE);
  assign bit_end     = baud_tick && (tick_cnt == CW'(OVERSAMPLE - 1));
  assign last_stop   = (state == STOP2) || (state == STOP1 && !lcr[2]);
  assign frame_done  = last_stop && bit_end;
  assign load_direct = tx_start && tx_ready && (state == IDLE);

`ifdef CONTROLUNIT_TX_HOLD_EN
  logic       hold_valid;
  logic [7:0] hold_data;
  logic [4:0] hold_lcr;

  assign tx_ready  = !hold_valid;
  // a held request starts either straight out of the final stop bit or from idle
  assign load_hold = hold_valid && (state == IDLE || frame_done);
  assign src_data  = load_hold ? hold_data : tx_data;
  assign src_lcr   = load_hold ? hold_lcr  : line_control_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_lcr   <= '0;
    end else if (tx_start && !hold_valid && tx_busy) begin
      hold_valid <= 1'b1;
      hold_data  <= tx_data;
      hold_lcr   <= line_control_reg;
    end else if (load_hold) begin
      hold_valid <= 1'b0;
    end
  end
`else
  assign tx_ready  = !tx_busy && (state == IDLE);
  assign load_hold = 1'b0;
  assign src_data  = tx_data;
  assign src_lcr   = line_control_reg;
`endif

  assign load      = load_direct || load_hold;
  assign frame_nxt = load ? build_frame(src_data, src_lcr) : parallel_data_tx;
  assign data_bits = frame_nxt[8:1];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && bit_idx == {1'b1, lcr[1:0]}) state_nxt = lcr[3] ? PARITY : STOP1;
      PARITY:  if (bit_end) state_nxt = STOP1;
      STOP1:   if (bit_end) state_nxt = lcr[2] ? STOP2 : (load ? START : IDLE);
      STOP2:   if (bit_end) state_nxt = load ? START : IDLE;
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state || bit_end)      tick_nxt = '0;
    else if (baud_tick && state != IDLE)    tick_nxt = tick_cnt + 1'b1;
    else                                    tick_nxt = tick_cnt;

    if (state_nxt != state)                 bit_nxt = '0;
    else if (state == DATA && bit_end)      bit_nxt = bit_idx + 1'b1;
    else                                    bit_nxt = bit_idx;

    case (state_nxt)
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = data_bits[bit_nxt];
      PARITY:  serial_nxt = frame_nxt[9];
      default: serial_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                  <= IDLE;
      tick_cnt               <= '0;
      bit_idx                <= '0;
      lcr                    <= '0;
      parallel_data_tx       <= 11'h7FF;
      tx_serial              <= 1'b1;
      transmission_done_flag <= 1'b0;
    end else begin
      state                  <= state_nxt;
      tick_cnt               <= tick_nxt;
      bit_idx                <= bit_nxt;
      tx_serial              <= serial_nxt;
      transmission_done_flag <= frame_done;
      if (load) begin
        lcr              <= src_lcr[3:0];
        parallel_data_tx <= frame_nxt;
      end
    end
  end

endmodule

// File: tb/tb_controlunit_tx.sv
// Self-checking bench for controlunit_tx: a bit-list reference model drives baud ticks and checks every clock.
module tb_controlunit_tx;
  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  tx_data = '0;
  logic [4:0]  line_control_reg = '0;
  logic        tx_start = 1'b0;
  logic        baud_tick = 1'b0;
  logic        tx_ready, tx_busy, tx_serial, transmission_done_flag;
  logic [10:0] parallel_data_tx;

  int n_checks = 0;
  int n_fail   = 0;
  bit hold_full = 1'b0;

`ifdef CONTROLUNIT_TX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  controlunit_tx #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .line_control_reg(line_control_reg),
    .tx_start(tx_start), .baud_tick(baud_tick), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .tx_serial(tx_serial), .parallel_data_tx(parallel_data_tx),
    .transmission_done_flag(transmission_done_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic [4:0] l);
    int n, ones;
    logic [10:0] f;
    n = 5 + int'(l[1:0]);
    ones = 0;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++)
      if (i < n) begin
        f[1+i] = d[i];
        ones += int'(d[i]);
      end
    if (l[3]) f[9] = l[4] ? (ones % 2 == 1) : (ones % 2 == 0);
    return f;
  endfunction

  task automatic accept(input logic [7:0] d, input logic [4:0] l);
    @(negedge clk);
    tx_data = d; line_control_reg = l; tx_start = 1'b1; baud_tick = 1'b1;
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL accept_ready got=%b exp=1", tx_ready);
    end
    @(negedge clk);
    tx_start = 1'b0; tx_data = 8'($urandom); line_control_reg = 5'($urandom);
    n_checks++;
    if ({parallel_data_tx, tx_busy} !== {model_frame(d, l), 1'b1}) begin
      n_fail++;
      $display("FAIL accept_frame got=%h busy=%b exp=%h busy=1", parallel_data_tx, tx_busy, model_frame(d, l));
    end
  endtask

  // Starts at the negedge just after START entry; each expected line bit lasts OS bench-driven ticks.
  task automatic drive_frame(input logic [7:0] d, input logic [4:0] l, input int period,
                             input int stop_bit, input bit inject);
    bit q[$];
    int bi, tk, cyc, n;
    bit inj_done, inj_now, chain;
    logic [10:0] f;
    f = model_frame(d, l);
    n = 5 + int'(l[1:0]);
    q.push_back(1'b0);
    for (int i = 0; i < n; i++) q.push_back(d[i]);
    if (l[3]) q.push_back(f[9]);
    q.push_back(1'b1);
    if (l[2]) q.push_back(1'b1);
    bi = 0; tk = 0; cyc = 0; inj_done = 1'b0;
    while (bi < q.size()) begin
      n_checks++;
      if ({tx_serial, tx_busy, tx_ready, transmission_done_flag, parallel_data_tx} !==
          {q[bi], 1'b1, HOLD && !hold_full, 1'b0, f}) begin
        n_fail++;
        $display("FAIL frame_step d=%h lcr=%b bit=%0d tick=%0d got ser=%b busy=%b rdy=%b done=%b par=%h exp ser=%b busy=1 rdy=%b done=0 par=%h",
                 d, l, bi, tk, tx_serial, tx_busy, tx_ready, transmission_done_flag, parallel_data_tx,
                 q[bi], HOLD && !hold_full, f);
      end
      if (stop_bit >= 0 && bi == stop_bit && tk == 2) return;
      inj_now = inject && !inj_done && bi == 3;
      if (inj_now) begin
        tx_start = 1'b1; tx_data = 8'h3C; line_control_reg = 5'b00011; inj_done = 1'b1;
      end
      baud_tick = (cyc % period == 0);
      cyc++;
      @(posedge clk);
      if (inj_now && HOLD) hold_full = 1'b1;
      if (baud_tick) begin
        tk++;
        if (tk == OS) begin tk = 0; bi++; end
      end
      @(negedge clk);
      if (inj_now) begin
        tx_start = 1'b0; tx_data = 8'($urandom); line_control_reg = 5'($urandom);
      end
    end
    chain = hold_full;
    n_checks++;
    if ({tx_serial, tx_busy, transmission_done_flag} !== {!chain, chain, 1'b1}) begin
      n_fail++;
      $display("FAIL frame_end d=%h got ser=%b busy=%b done=%b exp ser=%b busy=%b done=1",
               d, tx_serial, tx_busy, transmission_done_flag, !chain, chain);
    end
    if (chain) begin
      hold_full = 1'b0;
      n_checks++;
      if ({tx_ready, parallel_data_tx} !== {1'b1, model_frame(8'h3C, 5'b00011)}) begin
        n_fail++;
        $display("FAIL hold_handoff got rdy=%b par=%h exp rdy=1 par=%h",
                 tx_ready, parallel_data_tx, model_frame(8'h3C, 5'b00011));
      end
    end else begin
      baud_tick = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({tx_serial, tx_busy, transmission_done_flag, tx_ready, parallel_data_tx} !==
          {1'b1, 1'b0, 1'b0, 1'b1, f}) begin
        n_fail++;
        $display("FAIL after_done got ser=%b busy=%b done=%b rdy=%b par=%h exp 1 0 0 1 %h",
                 tx_serial, tx_busy, transmission_done_flag, tx_ready, parallel_data_tx, f);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #13;
    n_checks++;
    if ({tx_serial, tx_busy, tx_ready, transmission_done_flag, parallel_data_tx} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 11'h7FF}) begin
      n_fail++;
      $display("FAIL reset_state got ser=%b busy=%b rdy=%b done=%b par=%h exp 1 0 1 0 7ff",
               tx_serial, tx_busy, tx_ready, transmission_done_flag, parallel_data_tx);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic_frame();
    accept(8'hA5, 5'b00011);
    n_checks++;
    if (parallel_data_tx !== 11'h74A) begin
      n_fail++; $display("FAIL basic_frame_bits got=%h exp=74a", parallel_data_tx);
    end
    drive_frame(8'hA5, 5'b00011, 1, -1, 1'b0);
  endtask

  task automatic test_parity();
    accept(8'h07, 5'b01011);
    n_checks++;
    if (parallel_data_tx[9] !== 1'b0) begin
      n_fail++; $display("FAIL parity_odd got=%b exp=0", parallel_data_tx[9]);
    end
    drive_frame(8'h07, 5'b01011, 1, -1, 1'b0);
    accept(8'h07, 5'b11011);
    n_checks++;
    if (parallel_data_tx[9] !== 1'b1) begin
      n_fail++; $display("FAIL parity_even got=%b exp=1", parallel_data_tx[9]);
    end
    drive_frame(8'h07, 5'b11011, 1, -1, 1'b0);
  endtask

  task automatic test_short_word();
    accept(8'hFF, 5'b00100);
    n_checks++;
    if (parallel_data_tx !== 11'h7FE) begin
      n_fail++; $display("FAIL short_word_bits got=%h exp=7fe", parallel_data_tx);
    end
    drive_frame(8'hFF, 5'b00100, 1, -1, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [4:0] l;
    int p;
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      l = 5'($urandom);
      p = $urandom_range(1, 3);
      accept(d, l);
      drive_frame(d, l, p, -1, 1'b0);
    end
  endtask

  task automatic test_abort();
    accept(8'h96, 5'b01111);
    drive_frame(8'h96, 5'b01111, 4, 4, 1'b0);
    #2 rst = 1'b0;
    hold_full = 1'b0;
    #1;
    n_checks++;
    if ({tx_serial, tx_busy, tx_ready, transmission_done_flag, parallel_data_tx} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 11'h7FF}) begin
      n_fail++;
      $display("FAIL abort_reset got ser=%b busy=%b rdy=%b done=%b par=%h exp 1 0 1 0 7ff",
               tx_serial, tx_busy, tx_ready, transmission_done_flag, parallel_data_tx);
    end
    @(negedge clk);
    rst = 1'b1;
    baud_tick = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_serial, tx_busy, transmission_done_flag} !== 3'b100) begin
        n_fail++;
        $display("FAIL abort_idle cyc=%0d got ser=%b busy=%b done=%b exp 1 0 0",
                 c, tx_serial, tx_busy, transmission_done_flag);
      end
    end
    accept(8'h5A, 5'b11011);
    drive_frame(8'h5A, 5'b11011, 4, -1, 1'b0);
  endtask

  task automatic test_busy_request();
    accept(8'hC3, 5'b00011);
    drive_frame(8'hC3, 5'b00011, 1, -1, 1'b1);
`ifdef CONTROLUNIT_TX_HOLD_EN
    drive_frame(8'h3C, 5'b00011, 1, -1, 1'b0);
`else
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_serial, tx_busy, tx_ready, parallel_data_tx} !==
          {1'b1, 1'b0, 1'b1, model_frame(8'hC3, 5'b00011)}) begin
        n_fail++;
        $display("FAIL busy_ignored cyc=%0d got ser=%b busy=%b rdy=%b par=%h exp 1 0 1 %h",
                 c, tx_serial, tx_busy, tx_ready, parallel_data_tx, model_frame(8'hC3, 5'b00011));
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_short_word();
    test_random();
    test_abort();
    test_busy_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
